// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU state type and legality helpers
// used by the MEM-stage load/store unit.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    ERR  = 2'b11
  } lsu_state_t;

  // Unsigned variants have no store counterpart.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = (lo[0] == 1'b0);
      F3_W:        ok = (lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a raw read word and sign- or
// zero-extends it according to the RV32I load encoding.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_data = 32'h0000_0000;
    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      2'b11:   w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h00_0000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      F3_W:    o_data = i_rdata;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one access from EX, runs it over the
// req/gnt/rvalid data bus and returns extended load data with status flags.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               MemWrite,
  input  logic [2:0]         funct3,
  input  logic [31:0]        ALUResult,
  input  logic [31:0]        WriteData,
  mem_stage_lsu_if.master    dmem,
  output logic               out_valid,
  output logic [31:0]        ReadData,
  output logic               misaligned,
  output logic               bus_err,
  output logic               busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    r_state;
  lsu_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [2:0]    r_funct3;
  logic          r_we;
  logic          r_mis;
  logic          r_ill;

  logic          w_fire;
  logic          w_legal;
  logic          w_aligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_done;
  logic          w_timeout;
  logic [31:0]   w_load;

  assign w_fire    = in_valid & in_ready;
  assign w_legal   = f3_legal(funct3, MemWrite);
  assign w_aligned = addr_aligned(funct3, ALUResult[1:0]);

  // Byte enables and lane-replicated store data for the incoming op
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0000_0000;
    case (funct3)
      F3_B, F3_BU: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{WriteData[7:0]}};
      end
      F3_H, F3_HU: begin
        w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData[15:0]}};
      end
      F3_W: begin
        w_be    = 4'b1111;
        w_wdata = WriteData;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and completion decode
  always_comb begin
    w_next    = r_state;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fire) begin
          w_next = (w_legal && w_aligned) ? REQ : ERR;
        end else begin
          w_next = IDLE;
        end
      end
      REQ: begin
        if (r_cnt == CNT_LAST) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end else if (dmem.dmem_gnt) begin
          w_next = RESP;
        end else begin
          w_next = REQ;
        end
      end
      RESP: begin
        if (dmem.dmem_rvalid) begin
          w_next = IDLE;
          w_done = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end else begin
          w_next = RESP;
        end
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and open-access cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == REQ || r_state == RESP) && w_next != IDLE) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Capture of the accepted operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_be     <= 4'b0000;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_fire) begin
      r_addr   <= ALUResult;
      r_wdata  <= w_wdata;
      r_be     <= w_be;
      r_funct3 <= funct3;
      r_we     <= MemWrite;
      r_ill    <= ~w_legal;
      r_mis    <= w_legal & ~w_aligned;
    end
  end

  load_align u_load_align (
    .i_rdata   (dmem.dmem_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load)
  );

  assign dmem.dmem_req   = (r_state == REQ);
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = {r_addr[31:2], 2'b00};
  assign dmem.dmem_be    = r_be;
  assign dmem.dmem_wdata = r_wdata;

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign out_valid  = w_done | w_timeout | (r_state == ERR);
  assign ReadData   = (w_done && !r_we) ? w_load : 32'h0000_0000;
  assign misaligned = (r_state == ERR) & r_mis;
  assign bus_err    = w_timeout | ((r_state == ERR) & r_ill);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: stores, sign/zero-extended
// loads, misaligned/illegal ops, bus timeout and reset during an access.
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        out_valid;
  logic [31:0] ReadData;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  int n_assert;
  int n_fail;

  mem_stage_lsu_if bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .dmem       (bus),
    .out_valid  (out_valid),
    .ReadData   (ReadData),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic [3:0] be_exp,
                           input logic [31:0] wd_exp, input logic [31:0] rd_exp);
    @(negedge clk);
    in_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = addr; WriteData = wdata;
    #1;
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; bus.dmem_gnt = 1'b1;
    #1;
    chk({tag, "_req"},   {31'd0, bus.dmem_req}, 32'd1);
    chk({tag, "_we"},    {31'd0, bus.dmem_we}, {31'd0, we});
    chk({tag, "_addr"},  bus.dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"},    {28'd0, bus.dmem_be}, {28'd0, be_exp});
    chk({tag, "_wdata"}, bus.dmem_wdata, wd_exp);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = rdata;
    #1;
    chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_rdata"},  ReadData, rd_exp);
    chk({tag, "_flags"},  {30'd0, misaligned, bus_err}, 32'd0);
    @(negedge clk);
    bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0000_0000;
    #1;
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"},  {30'd0, busy, in_ready}, 32'd1);
  endtask

  task automatic do_error(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic mis_exp, input logic err_exp);
    @(negedge clk);
    in_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = addr; WriteData = 32'h5555_5555;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_noreq"},  {31'd0, bus.dmem_req}, 32'd0);
    chk({tag, "_ovalid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_mis"},    {31'd0, misaligned}, {31'd0, mis_exp});
    chk({tag, "_err"},    {31'd0, bus_err}, {31'd0, err_exp});
    chk({tag, "_rdata"},  ReadData, 32'h0000_0000);
    @(negedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic early;
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0; in_valid = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0000_0000; WriteData = 32'h0000_0000;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0000_0000;

    @(negedge clk);
    #1;
    chk("rst_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_req",    {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_out",    {29'd0, out_valid, misaligned, bus_err}, 32'd0);
    chk("rst_rdata",  ReadData, 32'h0000_0000);
    chk("rst_bus",    {bus.dmem_addr[31:4], bus.dmem_be}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_access("sw",  1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000,
              4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
    do_access("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0000_0000, 32'h80FF_0000,
              4'b1000, 32'h0000_0000, 32'hFFFF_FF80);
    do_access("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0000_0000, 32'h80FF_0000,
              4'b1000, 32'h0000_0000, 32'h0000_0080);
    do_access("sh",  1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0000_0000,
              4'b1100, 32'h1234_1234, 32'h0000_0000);
    do_access("lhu", 1'b0, 3'b101, 32'h0000_0102, 32'h0000_0000, 32'hABCD_0000,
              4'b1100, 32'h0000_0000, 32'h0000_ABCD);
    do_access("lh",  1'b0, 3'b001, 32'h0000_0100, 32'h0000_0000, 32'h1111_8001,
              4'b0011, 32'h0000_0000, 32'hFFFF_8001);
    do_access("sb",  1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h0000_0000,
              4'b0010, 32'hA5A5_A5A5, 32'h0000_0000);
    do_access("lw",  1'b0, 3'b010, 32'h0000_0208, 32'h0000_0000, 32'h1234_5678,
              4'b1111, 32'h0000_0000, 32'h1234_5678);

    do_error("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 1'b1, 1'b0);
    do_error("lh_mis", 1'b0, 3'b001, 32'h0000_0103, 1'b1, 1'b0);
    do_error("sbu_ill", 1'b1, 3'b100, 32'h0000_0100, 1'b0, 1'b1);
    do_error("f3_ill",  1'b0, 3'b111, 32'h0000_0100, 1'b0, 1'b1);

    // Timeout: granted load whose response never arrives
    @(negedge clk);
    in_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_0300;
    @(negedge clk);
    in_valid = 1'b0; bus.dmem_gnt = 1'b1;
    lat = 1;
    early = 1'b0;
    #1;
    while (!out_valid && lat <= 40) begin
      @(negedge clk);
      bus.dmem_gnt = 1'b0;
      lat++;
      #1;
    end
    chk("to_latency", lat, 32'd16);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_mis",     {31'd0, misaligned}, 32'd0);
    chk("to_rdata",   ReadData, 32'h0000_0000);
    @(negedge clk);
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("to_late_ignored", {31'd0, out_valid}, 32'd0);
    chk("to_ready",        {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0) early = 1'b1;
    chk("to_quiet", {31'd0, early}, 32'd0);

    // Reset while waiting in RESP
    @(negedge clk);
    in_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h0000_0400;
    @(negedge clk);
    in_valid = 1'b0; bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    #1;
    chk("rr_busy_before", {31'd0, busy}, 32'd1);
    bus.dmem_rvalid = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("rr_req",   {31'd0, bus.dmem_req}, 32'd0);
    chk("rr_busy",  {31'd0, busy}, 32'd0);
    chk("rr_ready", {31'd0, in_ready}, 32'd1);
    chk("rr_out",   {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    bus.dmem_rvalid = 1'b0;
    reset = 1'b1;
    do_access("post_rst", 1'b0, 3'b010, 32'h0000_0404, 32'h0000_0000, 32'hCAFE_F00D,
              4'b1111, 32'h0000_0000, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
